nco_sin_cos: RTL



---
 rtl/nco_sin_cos_pkg.sv | 13 +
 rtl/rom_sin_cos.sv | 83 ++++++++
 rtl/nco_sin_cos.sv | 75 +++++++
 3 files changed

// File: rtl/nco_sin_cos_pkg.sv
// Shared constants and quadrant helper for the NCO and its quarter-wave sin/cos core.
package nco_sin_cos_pkg;

    localparam int          CORE_LATENCY = 4;
    localparam int          NCO_LATENCY  = CORE_LATENCY + 1;
    localparam logic [15:0] LFSR_SEED    = 16'hACE1;

    // Returns {sin_negative, cos_negative} for a quadrant number.
    function automatic logic [1:0] quadrant_sign(input logic [1:0] quad);
        return {quad[1], quad[1] ^ quad[0]};
    endfunction

endpackage

// File: rtl/rom_sin_cos.sv
// Four-cycle quarter-wave sin/cos core: mirror/index, dual-read ROM, quarter-point
// correction with sign qualification, then two's-complement output.
module rom_sin_cos
    import nco_sin_cos_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter     HEXNAME = "sin-lut.hex"
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clkena,
    input  logic [WIDTH-1:0]        arg,
    output logic signed [WIDTH-1:0] sin,
    output logic signed [WIDTH-1:0] cos
);

    localparam int IW    = WIDTH - 2;
    localparam int DEPTH = 1 << IW;
    localparam real PI   = 3.14159265358979323846;

    logic [WIDTH-2:0] rom [DEPTH];

    function automatic logic [WIDTH-2:0] table_entry(input int k);
        real amp;
        amp = real'((longint'(1) << (WIDTH - 1)) - 1);
        return (WIDTH-1)'($rtoi(amp * $sin(real'(k) * PI / real'(longint'(1) << (WIDTH - 1))) + 0.5));
    endfunction

    initial begin
        for (int k = 0; k < DEPTH; k++) rom[k] = table_entry(k);
    end

    logic [IW-1:0]    idx, idx_neg;
    logic [1:0]       quad_neg, corr;
    logic [IW-1:0]    sin_idx1, cos_idx1;
    logic [1:0]       corr1, neg1, corr2, neg2, neg3;
    logic [WIDTH-2:0] sin_raw2, cos_raw2, sin_mag_c, cos_mag_c, sin_mag3, cos_mag3;

    assign idx      = arg[IW-1:0];
    assign idx_neg  = '0 - idx;
    assign quad_neg = quadrant_sign(arg[WIDTH-1 -: 2]);
    // Index 0 on the mirrored side would address sin(pi/2), which the table lacks.
    assign corr     = {arg[WIDTH-2] & (idx == '0), ~arg[WIDTH-2] & (idx == '0)};

    assign sin_mag_c = corr2[1] ? '1 : sin_raw2;
    assign cos_mag_c = corr2[0] ? '1 : cos_raw2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sin_idx1 <= '0;
            cos_idx1 <= '0;
            corr1    <= '0;
            neg1     <= '0;
            sin_raw2 <= '0;
            cos_raw2 <= '0;
            corr2    <= '0;
            neg2     <= '0;
            sin_mag3 <= '0;
            cos_mag3 <= '0;
            neg3     <= '0;
            sin      <= '0;
            cos      <= '0;
        end else if (clkena) begin
            sin_idx1 <= arg[WIDTH-2] ? idx_neg : idx;
            cos_idx1 <= arg[WIDTH-2] ? idx : idx_neg;
            corr1    <= corr;
            neg1     <= quad_neg;

            sin_raw2 <= rom[sin_idx1];
            cos_raw2 <= rom[cos_idx1];
            corr2    <= corr1;
            neg2     <= neg1;

            sin_mag3 <= sin_mag_c;
            cos_mag3 <= cos_mag_c;
            neg3     <= {neg2[1] & (sin_mag_c != '0), neg2[0] & (cos_mag_c != '0)};

            sin      <= neg3[1] ? -$signed({1'b0, sin_mag3}) : $signed({1'b0, sin_mag3});
            cos      <= neg3[0] ? -$signed({1'b0, cos_mag3}) : $signed({1'b0, cos_mag3});
        end
    end

endmodule

// File: rtl/nco_sin_cos.sv
// Quadrature NCO: phase accumulator, phase offset, valid pipeline and the sin/cos core.
// Optional NCO_SIN_COS_DITHER_EN adds LFSR dither below the phase truncation point.
module nco_sin_cos
    import nco_sin_cos_pkg::*;
#(
    parameter int PWIDTH  = 32,
    parameter int WIDTH   = 16,
    parameter     HEXNAME = "sin-lut.hex"
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clkena,
    input  logic [PWIDTH-1:0]       freq,
    input  logic [PWIDTH-1:0]       phase,
    input  logic                    sync,
    output logic signed [WIDTH-1:0] sin,
    output logic signed [WIDTH-1:0] cos,
    output logic                    valid
);

    logic [PWIDTH-1:0]      acc, offset;
    logic [WIDTH-1:0]       arg_reg;
    logic [NCO_LATENCY-1:0] valid_sr;

`ifdef NCO_SIN_COS_DITHER_EN
    logic [15:0]       lfsr;
    logic [PWIDTH-1:0] dither;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else if (clkena) begin
            if (sync) lfsr <= LFSR_SEED;
            else      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    // Only the bits that fall below the kept argument are dithered.
    always_comb begin
        dither = '0;
        for (int i = 0; i < PWIDTH - WIDTH && i < 16; i++) dither[i] = lfsr[i];
    end

    assign offset = acc + phase + dither;
`else
    assign offset = acc + phase;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            arg_reg  <= '0;
            valid_sr <= '0;
        end else if (clkena) begin
            acc      <= sync ? '0 : acc + freq;
            arg_reg  <= WIDTH'(offset >> (PWIDTH - WIDTH));
            valid_sr <= sync ? '0 : {valid_sr[NCO_LATENCY-2:0], 1'b1};
        end
    end

    assign valid = valid_sr[NCO_LATENCY-1];

    rom_sin_cos #(
        .WIDTH   (WIDTH),
        .HEXNAME (HEXNAME)
    ) u_rom (
        .clk    (clk),
        .reset  (reset),
        .clkena (clkena),
        .arg    (arg_reg),
        .sin    (sin),
        .cos    (cos)
    );

endmodule
